// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: 2-flop sync, stable-window filter, rise/fall ticks; long-press ticks when DEBOUNCER_MULTI_LONG_EN is defined.
// Latency: level and ticks change SyncStages+Window edges after a clean input step; long tick LongCycles after rise.
// Backpressure: none, free-running per channel; every output is a registered level or one-cycle pulse.
module debouncer_multi #(
    parameter int   Channels   = 4,
    parameter int   ClkRate    = 10_000_000,
    parameter int   Baud       = 10_000,
    parameter int   SyncStages = 2,
    parameter logic IdleLevel  = 1'b0,
    parameter int   LongCycles = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Channels-1:0] sw_i,
    output logic [Channels-1:0] db_level_o,
    output logic [Channels-1:0] db_rise_o,
    output logic [Channels-1:0] db_fall_o,
    output logic                db_any_o,
    output logic [Channels-1:0] db_long_o
);

    localparam int Window = ClkRate / Baud;
    localparam int CntW   = (Window > 1) ? $clog2(Window) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Window - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    generate
        if (Channels < 1) begin : g_bad_channels
            $error("debouncer_multi: Channels must be >= 1");
        end
        if (Window < 2) begin : g_bad_window
            $error("debouncer_multi: ClkRate/Baud must be >= 2");
        end
        if (SyncStages < 2) begin : g_bad_sync
            $error("debouncer_multi: SyncStages must be >= 2");
        end
        if (LongCycles < 1) begin : g_bad_long
            $error("debouncer_multi: LongCycles must be >= 1");
        end
    endgenerate

    logic [Channels-1:0][SyncStages-1:0] sync_q;
    logic [Channels-1:0][CntW-1:0]       cnt_q;
    logic [Channels-1:0][CntW-1:0]       cnt_d;
    logic [Channels-1:0]                 s;
    logic [Channels-1:0]                 level_d;
    logic [Channels-1:0]                 rise_d;
    logic [Channels-1:0]                 fall_d;

    always_comb begin
        s       = '0;
        cnt_d   = '0;
        level_d = db_level_o;
        rise_d  = '0;
        fall_d  = '0;
        for (int ch = 0; ch < Channels; ch++) begin
            s[ch] = sync_q[ch][SyncStages-1];
            // Any cycle where s agrees with the accepted level restarts the window.
            if (s[ch] != db_level_o[ch]) begin
                if (cnt_q[ch] == CntLast) begin
                    level_d[ch] = s[ch];
                    rise_d[ch]  = s[ch];
                    fall_d[ch]  = ~s[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CntOne;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= {(Channels * SyncStages){IdleLevel}};
            db_level_o <= {Channels{IdleLevel}};
            cnt_q      <= '0;
            db_rise_o  <= '0;
            db_fall_o  <= '0;
            db_any_o   <= 1'b0;
        end else begin
            for (int ch = 0; ch < Channels; ch++) begin
                sync_q[ch] <= {sync_q[ch][SyncStages-2:0], sw_i[ch]};
            end
            db_level_o <= level_d;
            cnt_q      <= cnt_d;
            db_rise_o  <= rise_d;
            db_fall_o  <= fall_d;
            db_any_o   <= |(rise_d | fall_d);
        end
    end

`ifdef DEBOUNCER_MULTI_LONG_EN
    localparam int LongW = $clog2(LongCycles + 1);
    localparam logic [LongW-1:0] LongLast = LongW'(LongCycles - 1);
    localparam logic [LongW-1:0] LongSat  = LongW'(LongCycles);
    localparam logic [LongW-1:0] LongOne  = LongW'(1);

    logic [Channels-1:0][LongW-1:0] lcnt_q;
    logic [Channels-1:0][LongW-1:0] lcnt_d;
    logic [Channels-1:0]            long_d;

    always_comb begin
        lcnt_d = lcnt_q;
        long_d = '0;
        for (int ch = 0; ch < Channels; ch++) begin
            if (rise_d[ch]) begin
                lcnt_d[ch] = '0;
            end else if (db_level_o[ch]) begin
                // Saturating one past the tick point keeps the pulse single until re-armed by a rise.
                if (lcnt_q[ch] == LongLast) begin
                    long_d[ch] = 1'b1;
                end
                if (lcnt_q[ch] != LongSat) begin
                    lcnt_d[ch] = lcnt_q[ch] + LongOne;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt_q    <= '0;
            db_long_o <= '0;
        end else begin
            lcnt_q    <= lcnt_d;
            db_long_o <= long_d;
        end
    end
`else
    assign db_long_o = '0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi with Window=10, SyncStages=2, LongCycles=50.
module tb_debouncer_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_i = 4'h0;
    logic [3:0] db_level_o;
    logic [3:0] db_rise_o;
    logic [3:0] db_fall_o;
    logic       db_any_o;
    logic [3:0] db_long_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debouncer_multi #(
        .Channels   (4),
        .ClkRate    (1000),
        .Baud       (100),
        .SyncStages (2),
        .IdleLevel  (1'b0),
        .LongCycles (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_i       (sw_i),
        .db_level_o (db_level_o),
        .db_rise_o  (db_rise_o),
        .db_fall_o  (db_fall_o),
        .db_any_o   (db_any_o),
        .db_long_o  (db_long_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sw_i = 4'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        sw_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({db_level_o, db_rise_o, db_fall_o, db_long_o, db_any_o} !== 17'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got lvl=%h rise=%h fall=%h long=%h any=%b, expected all 0",
                         i, db_level_o, db_rise_o, db_fall_o, db_long_o, db_any_o);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_checks++;
            if (i < 12) begin
                if (db_rise_o !== 4'h0 || db_any_o !== 1'b0 || db_level_o !== 4'h0) begin
                    n_fail++;
                    $display("FAIL reset_early cyc%0d: got rise=%h any=%b lvl=%h, expected 0/0/0",
                             i, db_rise_o, db_any_o, db_level_o);
                end
            end else begin
                if (db_rise_o !== 4'hF || db_any_o !== 1'b1 || db_level_o !== 4'hF) begin
                    n_fail++;
                    $display("FAIL reset_rise cyc12: got rise=%h any=%b lvl=%h, expected F/1/F",
                             db_rise_o, db_any_o, db_level_o);
                end
            end
        end
        tick();
        n_checks++;
        if (db_rise_o !== 4'h0 || db_any_o !== 1'b0 || db_level_o !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_after: got rise=%h any=%b lvl=%h, expected 0/0/F",
                     db_rise_o, db_any_o, db_level_o);
        end
    endtask

    task automatic test_glitch();
        int rises;
        int rise_at;
        int fall_at;
        int falls;
        do_reset();
        rises = 0;
        sw_i[0] = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 9) sw_i[0] = 1'b0;
            if (db_rise_o[0] || db_fall_o[0]) rises++;
        end
        n_checks++;
        if (rises != 0 || db_level_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_9: got ticks=%0d lvl=%b, expected 0 ticks lvl 0", rises, db_level_o[0]);
        end
        rises = 0; falls = 0; rise_at = -1; fall_at = -1;
        sw_i[0] = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 10) sw_i[0] = 1'b0;
            if (db_rise_o[0] === 1'b1) begin rises++; rise_at = i; end
            if (db_fall_o[0] === 1'b1) begin falls++; fall_at = i; end
        end
        n_checks++;
        if (rises != 1 || rise_at != 12) begin
            n_fail++;
            $display("FAIL glitch_10_rise: got %0d rises at %0d, expected 1 at 12", rises, rise_at);
        end
        n_checks++;
        if (falls != 1 || fall_at != 22) begin
            n_fail++;
            $display("FAIL glitch_10_fall: got %0d falls at %0d, expected 1 at 22", falls, fall_at);
        end
    endtask

    task automatic test_bounce();
        int early;
        int rises;
        int rise_at;
        do_reset();
        early = 0;
        for (int i = 0; i < 30; i++) begin
            sw_i[1] = ((i / 3) % 2) == 0;
            tick();
            if (db_rise_o[1] || db_fall_o[1] || db_level_o[1]) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL bounce_quiet: got %0d tick/level events, expected 0", early);
        end
        sw_i[1] = 1'b1;
        rises = 0; rise_at = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (db_rise_o[1] === 1'b1) begin rises++; rise_at = i; end
        end
        n_checks++;
        if (rises != 1 || rise_at != 12 || db_level_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_rise: got %0d rises at %0d lvl=%b, expected 1 at 12 lvl 1",
                     rises, rise_at, db_level_o[1]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        sw_i = 4'b1000;
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (db_level_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL simul_preset: got lvl=%b, expected 1000", db_level_o);
        end
        sw_i = 4'b0100;
        for (int i = 1; i <= 13; i++) begin
            tick();
            n_checks++;
            if (i == 12) begin
                if (db_rise_o !== 4'b0100 || db_fall_o !== 4'b1000 || db_any_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL simul_tick: got rise=%b fall=%b any=%b, expected 0100/1000/1",
                             db_rise_o, db_fall_o, db_any_o);
                end
            end else if (db_rise_o !== 4'h0 || db_fall_o !== 4'h0 || db_any_o !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_idle cyc%0d: got rise=%b fall=%b any=%b, expected 0/0/0",
                         i, db_rise_o, db_fall_o, db_any_o);
            end
        end
    endtask

    task automatic test_long_press();
        int rise_at;
        int long_at;
        int longs;
        do_reset();
        rise_at = -1; long_at = -1; longs = 0;
        sw_i[0] = 1'b1;
        for (int i = 1; i <= 270; i++) begin
            tick();
            if (db_rise_o[0] === 1'b1) rise_at = i;
            if (db_long_o !== 4'h0) begin longs++; long_at = i; end
        end
        n_checks++;
        if (rise_at != 12) begin
            n_fail++;
            $display("FAIL long_rise: got rise at %0d, expected 12", rise_at);
        end
`ifdef DEBOUNCER_MULTI_LONG_EN
        n_checks++;
        if (longs != 1 || long_at != 62) begin
            n_fail++;
            $display("FAIL long_pulse: got %0d pulses, last at %0d, expected 1 at 62", longs, long_at);
        end
`else
        n_checks++;
        if (longs != 0) begin
            n_fail++;
            $display("FAIL long_disabled: got %0d pulses (last at %0d), expected 0", longs, long_at);
        end
`endif
    endtask

    task automatic test_reset_mid_window();
        int rises;
        int rise_at;
        do_reset();
        sw_i[1] = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (db_rise_o !== 4'h0 || db_any_o !== 1'b0 || db_level_o !== 4'h0) begin
                n_fail++;
                $display("FAIL midrst_hold cyc%0d: got rise=%h any=%b lvl=%h, expected 0/0/0",
                         i, db_rise_o, db_any_o, db_level_o);
            end
        end
        rst = 1'b0;
        rises = 0; rise_at = -1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (db_rise_o[1] === 1'b1) begin rises++; rise_at = i; end
        end
        n_checks++;
        if (rises != 1 || rise_at != 12) begin
            n_fail++;
            $display("FAIL midrst_rise: got %0d rises at %0d, expected 1 at 12", rises, rise_at);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_long_press();
        test_reset_mid_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
